// File: rtl/debounce_pkg.sv
// Shared types and helpers for the front-panel button debouncer.
// The optional auto-repeat feature is enabled with BUTTON_AUTO_REPEAT_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } btn_state_e;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-FF synchroniser, stable-time filter, press/long FSM.
// Auto-repeat of press_pulse while in LONG is built only with BUTTON_AUTO_REPEAT_EN.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES   = 100_000_000
`ifdef BUTTON_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 20_000_000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw_n,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse,
    output logic o_long_held
);

    localparam int STABLE_W = cnt_w(STABLE_CYCLES);
    localparam int HOLD_W   = $clog2(LONG_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(LONG_CYCLES - 1);

    logic                r_sync_meta;
    logic                r_sync;
    logic [STABLE_W-1:0] r_stable_cnt;
    logic                r_level;
    logic                w_stable_done;
    logic                w_rise;
    logic                w_fall;

    btn_state_e          r_state;
    btn_state_e          w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic                w_press_nxt;
    logic                w_release_nxt;
    logic                w_long_nxt;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_W = cnt_w(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0]    r_rep_cnt;
    logic [REP_W-1:0]    w_rep_nxt;
`endif

    // The counter only ever runs while sync disagrees with the accepted level,
    // so reaching its last value means STABLE_CYCLES consecutive mismatches.
    assign w_stable_done = (r_sync != r_level) && (r_stable_cnt == STABLE_LAST);
    assign w_rise        = w_stable_done &&  r_sync;
    assign w_fall        = w_stable_done && !r_sync;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta  <= 1'b0;
            r_sync       <= 1'b0;
            r_stable_cnt <= '0;
            r_level      <= 1'b0;
        end else begin
            r_sync_meta <= i_raw_n;
            r_sync      <= r_sync_meta;
            if (r_sync == r_level) begin
                r_stable_cnt <= '0;
            end else if (w_stable_done) begin
                r_level      <= r_sync;
                r_stable_cnt <= '0;
            end else begin
                r_stable_cnt <= r_stable_cnt + STABLE_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can
        // leave a signal unassigned and infer a latch.
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        w_rep_nxt     = '0;
`endif
        case (r_state)
            RELEASED: begin
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_hold_nxt  = '0;
                    w_press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                // A release landing on the long threshold takes priority.
                if (w_fall) begin
                    w_state_nxt   = RELEASED;
                    w_release_nxt = 1'b1;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = LONG;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_state_nxt   = RELEASED;
                    w_release_nxt = 1'b1;
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (r_rep_cnt == REP_LAST) begin
                    w_press_nxt = 1'b1;
                end else begin
                    w_rep_nxt = r_rep_cnt + REP_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RELEASED;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_nxt;
        end
    end
`endif

    assign o_btn_level     = r_level;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_long_pulse    = r_long;
    assign o_long_held     = (r_state == LONG);

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel debouncer for front-panel buttons and limit switches.
// Define BUTTON_AUTO_REPEAT_EN to add press_pulse auto-repeat while a button is long-held.
module button_debounce_multi
    import debounce_pkg::*;
#(
    parameter int               N_BTN           = 4,
    parameter int               STABLE_CYCLES   = 1_000_000,
    parameter int               LONG_CYCLES     = 100_000_000,
    parameter int               REPEAT_CYCLES   = 20_000_000,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = {N_BTN{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] long_held
);

    if (STABLE_CYCLES < 1 || LONG_CYCLES <= STABLE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_debounce_multi: invalid timing parameters");
    end

    // Normalise polarity before synchronising so a cleared flop always means released.
    logic [N_BTN-1:0] w_raw_n;
    assign w_raw_n = btn_raw ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
            ,
            .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .i_raw_n         (w_raw_n[i]),
            .o_btn_level     (btn_level[i]),
            .o_press_pulse   (press_pulse[i]),
            .o_release_pulse (release_pulse[i]),
            .o_long_pulse    (long_pulse[i]),
            .o_long_held     (long_held[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Self-checking bench for button_debounce_multi: directed scenarios plus random presses
// compared every cycle against a time-since-press reference model.
module tb_button_debounce_multi;

    localparam int         N_BTN  = 2;
    localparam int         STABLE = 4;
    localparam int         LONG   = 20;
    localparam int         REPEAT = 8;
    localparam logic [1:0] MASK   = 2'b10;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] long_held;

    always #5 clk = ~clk;

    button_debounce_multi #(
        .N_BTN           (N_BTN),
        .STABLE_CYCLES   (STABLE),
        .LONG_CYCLES     (LONG),
        .REPEAT_CYCLES   (REPEAT),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .long_held     (long_held)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw delay line, mismatch run length, time since accepted press.
    bit         m_d1   [N_BTN];
    bit         m_d2   [N_BTN];
    bit         m_lvl  [N_BTN];
    int         m_run  [N_BTN];
    int         m_hold [N_BTN];
    logic [1:0] e_level, e_press, e_release, e_long, e_held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_BTN; c++) begin
            m_d1[c]   = 1'b0;
            m_d2[c]   = 1'b0;
            m_lvl[c]  = 1'b0;
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
        e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_held = '0;
    endtask

    task automatic model_edge();
        bit raw_n;
        bit sync;
        if (rst) begin
            model_reset();
            return;
        end
        e_press = '0; e_release = '0; e_long = '0;
        for (int c = 0; c < N_BTN; c++) begin
            raw_n   = btn_raw[c] ^ MASK[c];
            sync    = m_d2[c];
            m_d2[c] = m_d1[c];
            m_d1[c] = raw_n;
            m_run[c] = (sync != m_lvl[c]) ? m_run[c] + 1 : 0;
            if (m_run[c] == STABLE) begin
                m_lvl[c] = sync;
                m_run[c] = 0;
                if (sync) begin
                    e_press[c] = 1'b1;
                    m_hold[c]  = 0;
                end else begin
                    e_release[c] = 1'b1;
                end
            end else if (m_lvl[c]) begin
                m_hold[c]++;
                if (m_hold[c] == LONG) e_long[c] = 1'b1;
                if (REP_EN && m_hold[c] > LONG && ((m_hold[c] - LONG) % REPEAT) == 0)
                    e_press[c] = 1'b1;
            end
            e_level[c] = m_lvl[c];
            e_held[c]  = m_lvl[c] && (m_hold[c] >= LONG);
        end
    endtask

    task automatic compare_all();
        check("btn_level",     btn_level,     e_level);
        check("press_pulse",   press_pulse,   e_press);
        check("release_pulse", release_pulse, e_release);
        check("long_pulse",    long_pulse,    e_long);
        check("long_held",     long_held,     e_held);
    endtask

    // Inputs change on the falling edge; outputs are compared on the next falling edge.
    task automatic step(input logic [1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int         p_at, l_at, r_at, cnt, last;
        logic       rose, held_at_rel, rel_seen;
        logic [16:0] pat;
        int         dur [N_BTN];
        bit         cur [N_BTN];
        logic [1:0] raw;

        rst     = 1'b1;
        btn_raw = MASK;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Idle after reset: both channels released.
        repeat (50) step(2'b10);
        check("idle_level", btn_level, 2'b00);

        // Single press on channel 0: level and press exactly 6 cycles after the raw edge.
        for (int i = 1; i <= 6; i++) begin
            step(2'b11);
            check("t2_level", btn_level[0], 32'(i == 6));
            check("t2_press", press_pulse[0], 32'(i == 6));
        end
        step(2'b11);
        check("t2_press_width", press_pulse[0], 0);
        for (int i = 1; i <= 6; i++) begin
            step(2'b10);
            check("t2_release", release_pulse[0], 32'(i == 6));
        end
        repeat (4) step(2'b10);

        // Bouncy burst must never be accepted.
        rose = 1'b0;
        pat  = 17'b0000000000_1110111;
        for (int i = 0; i < 17; i++) begin
            step(pat[i] ? 2'b11 : 2'b10);
            rose = rose | btn_level[0] | press_pulse[0] | release_pulse[0];
        end
        check("t3_no_rise", rose, 0);

        // Active-low channel 1 long press then release.
        p_at = -1; l_at = -1;
        for (int i = 1; i <= 30; i++) begin
            step(2'b00);
            if (press_pulse[1] && p_at < 0) p_at = i;
            if (long_pulse[1] && l_at < 0) l_at = i;
        end
        check("t4_press_at", p_at, 6);
        check("t4_long_at", l_at, 26);
        check("t4_long_held", long_held[1], 1);
        r_at = -1; held_at_rel = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(2'b10);
            if (release_pulse[1] && r_at < 0) begin
                r_at        = i;
                held_at_rel = long_held[1];
            end
        end
        check("t4_release_at", r_at, 6);
        check("t4_held_cleared", held_at_rel, 0);

        // Long hold on channel 0: repeats only with the auto-repeat build.
        cnt = 0; last = -1; l_at = -1;
        for (int i = 1; i <= 56; i++) begin
            step(2'b11);
            if (press_pulse[0]) begin
                cnt++;
                last = i;
            end
            if (long_pulse[0] && l_at < 0) l_at = i;
        end
        check("t5_press_count", cnt, REP_EN ? 4 : 1);
        check("t5_last_press", last, REP_EN ? 50 : 6);
        check("t5_long_at", l_at, 26);

        // Reset while still pressed: no release, fresh press 6 cycles after deassert.
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (3) step(2'b11);
        rst = 1'b0;
        p_at = -1; rel_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(2'b11);
            if (press_pulse[0] && p_at < 0) p_at = i;
            rel_seen = rel_seen | release_pulse[0];
        end
        check("t6_press_at", p_at, 6);
        check("t6_no_release", rel_seen, 0);
        repeat (10) step(2'b10);

        // Random press/bounce traffic on both channels, with one reset mid-run.
        for (int c = 0; c < N_BTN; c++) begin
            cur[c] = 1'b0;
            dur[c] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_BTN; c++) begin
                if (dur[c] == 0) begin
                    cur[c] = ~cur[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 40));
                end
                dur[c]--;
                raw[c] = cur[c] ^ MASK[c];
            end
            if (n == 1500) begin
                rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                repeat (2) step(raw);
                rst = 1'b0;
            end
            step(raw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
